// File: rtl/sin_meas.sv
// Sine-wave ADC characteriser: tracks min/max over NUM_PERIODS rising midscale
// crossings and reports peak-to-peak, midpoint and average period in samples.
module sin_meas #(
    parameter int CODE_W      = 8,
    parameter int HYST        = 2,
    parameter int NUM_PERIODS = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CODE_W-1:0] code_max,
    output logic [CODE_W-1:0] code_min,
    output logic [CODE_W-1:0] amp_pp,
    output logic [CODE_W-1:0] dc_mid,
    output logic [CNT_W-1:0]  period_cycles
);
    localparam logic [CODE_W-1:0] LO_TH   = CODE_W'(2 ** (CODE_W - 1) - HYST);
    localparam logic [CODE_W-1:0] HI_TH   = CODE_W'(2 ** (CODE_W - 1) + HYST);
    localparam int                SHIFT   = $clog2(NUM_PERIODS);
    localparam int                XC_W    = SHIFT + 1;
    localparam logic [XC_W-1:0]   XC_LAST = XC_W'(NUM_PERIODS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XC_W-1:0]   xc_q, xc_d;
    logic              below_q, below_d;
    logic              err_q, err_d;
    logic [CODE_W-1:0] res_max_q, res_max_d, res_min_q, res_min_d;
    logic [CODE_W-1:0] amp_q, amp_d, dc_q, dc_d;
    logic [CNT_W-1:0]  per_q, per_d;

    logic              is_low, is_cross, cnt_full, load_res, timeout;
    logic [CODE_W-1:0] min_upd, max_upd;
    logic [CODE_W:0]   sum;

    assign is_low   = (code_in <= LO_TH);
    assign is_cross = below_q && (code_in >= HI_TH);
    assign cnt_full = (cnt_q == {CNT_W{1'b1}});
    assign min_upd  = (code_in < min_q) ? code_in : min_q;
    assign max_upd  = (code_in > max_q) ? code_in : max_q;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        max_d     = max_q;
        cnt_d     = cnt_q;
        xc_d      = xc_q;
        below_d   = below_q;
        err_d     = err_q;
        res_max_d = res_max_q;
        res_min_d = res_min_q;
        amp_d     = amp_q;
        dc_d      = dc_q;
        per_d     = per_q;
        load_res  = 1'b0;
        timeout   = 1'b0;
        sum       = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_ARM;
                    min_d   = '1;
                    max_d   = '0;
                    cnt_d   = '0;
                    xc_d    = '0;
                    below_d = 1'b0;
                end
            end
            S_ARM: begin
                if (code_valid) begin
                    if (cnt_full) begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                        timeout  = 1'b1;
                    end else if (is_cross) begin
                        // The arming crossing opens the window as sample index 0.
                        state_d = S_MEAS;
                        cnt_d   = '0;
                        min_d   = min_upd;
                        max_d   = max_upd;
                        below_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (is_low) below_d = 1'b1;
                    end
                end
            end
            S_MEAS: begin
                if (code_valid) begin
                    min_d = min_upd;
                    max_d = max_upd;
                    if (cnt_full) begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                        timeout  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (is_cross) begin
                            below_d = 1'b0;
                            xc_d    = xc_q + XC_W'(1);
                            if (xc_q == XC_LAST) begin
                                state_d  = S_DONE;
                                load_res = 1'b1;
                            end
                        end else if (is_low) begin
                            below_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Results are taken from the post-update working values so the final sample counts.
        if (load_res) begin
            sum       = {1'b0, max_d} + {1'b0, min_d};
            res_max_d = max_d;
            res_min_d = min_d;
            amp_d     = max_d - min_d;
            dc_d      = CODE_W'(sum >> 1);
            per_d     = timeout ? {CNT_W{1'b1}} : (cnt_d >> SHIFT);
            err_d     = timeout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            min_q     <= '0;
            max_q     <= '0;
            cnt_q     <= '0;
            xc_q      <= '0;
            below_q   <= 1'b0;
            err_q     <= 1'b0;
            res_max_q <= '0;
            res_min_q <= '0;
            amp_q     <= '0;
            dc_q      <= '0;
            per_q     <= '0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            max_q     <= max_d;
            cnt_q     <= cnt_d;
            xc_q      <= xc_d;
            below_q   <= below_d;
            err_q     <= err_d;
            res_max_q <= res_max_d;
            res_min_q <= res_min_d;
            amp_q     <= amp_d;
            dc_q      <= dc_d;
            per_q     <= per_d;
        end
    end

    assign busy          = (state_q == S_ARM) || (state_q == S_MEAS);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign code_max      = res_max_q;
    assign code_min      = res_min_q;
    assign amp_pp        = amp_q;
    assign dc_mid        = dc_q;
    assign period_cycles = per_q;
endmodule
